// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle chunked adder.
package seq_adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int unsigned nchunks(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   // Elaboration-time guard: operands must split into whole chunks.
   function automatic bit chunk_fits(input int unsigned width, input int unsigned chunk);
      return (chunk != 0) && (width % chunk == 0);
   endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle for seq_chunk_adder: operands and start in, result and status out.
interface seq_chunk_adder_if #(parameter int unsigned WIDTH = 32);

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (output start, sub, x, y, cin,
                   input  busy, done, sum, cout, overflow);

   modport slave  (input  start, sub, x, y, cin,
                   output busy, done, sum, cout, overflow);

endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational W-bit ripple-carry adder used once per cycle on one operand chunk.
module chunk_adder #(parameter int unsigned W = 8) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic c;

   always_comb begin
      s = '0;
      c = ci;
      for (int unsigned i = 0; i < W; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential adder/subtractor: CHUNK bits per clock, LS chunk first, carry held between chunks.
module seq_chunk_adder
   import seq_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input logic              clk,
   input logic              rst_n,
   seq_chunk_adder_if.slave bus
);

   localparam int unsigned     N    = nchunks(WIDTH, CHUNK);
   localparam int unsigned     IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

   if (!chunk_fits(WIDTH, CHUNK)) begin : g_width_check
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t           state;
   logic [WIDTH-1:0] a, b, psum, nxt_psum;
   logic             carry;
   logic [IDXW-1:0]  idx;
   logic [CHUNK-1:0] ca, cb, cs;
   logic             cco;
   logic             busy_r, done_r, cout_r, ovf_r;
   logic [WIDTH-1:0] sum_r;

   always_comb begin
      ca = a[idx*CHUNK +: CHUNK];
      cb = b[idx*CHUNK +: CHUNK];
   end

   chunk_adder #(.W(CHUNK)) u_chunk (
      .a  (ca),
      .b  (cb),
      .ci (carry),
      .s  (cs),
      .co (cco)
   );

   // Partial sum with the current chunk merged in, so the last edge can publish it directly.
   always_comb begin
      nxt_psum = psum;
      nxt_psum[idx*CHUNK +: CHUNK] = cs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a      <= '0;
         b      <= '0;
         psum   <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a      <= bus.x;
                  b      <= bus.sub ? ~bus.y : bus.y;
                  carry  <= bus.sub | bus.cin;
                  idx    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               psum  <= nxt_psum;
               carry <= cco;
               if (idx == LAST) begin
                  sum_r  <= nxt_psum;
                  cout_r <= cco;
                  ovf_r  <= (a[WIDTH-1] == b[WIDTH-1]) && (nxt_psum[WIDTH-1] != a[WIDTH-1]);
                  idx    <= '0;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.sum      = sum_r;
   assign bus.cout     = cout_r;
   assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder at WIDTH=16, CHUNK=4 with hand-computed results.
module tb_seq_chunk_adder;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   n, n2;

   seq_chunk_adder_if #(.WIDTH(16)) bus ();

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic cin, input logic sub,
                         input string tag);
      @(negedge clk);
      bus.x = x; bus.y = y; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, "_busy"}, bus.busy, 1'b1);
   endtask

   task automatic wait_done(input int limit, output int cnt);
      cnt = 0;
      while (bus.done !== 1'b1 && cnt < limit) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic check_result(input string tag, input logic [15:0] s, input logic c, input logic o);
      check({tag, "_done"}, bus.done, 1'b1);
      check({tag, "_busy_lo"}, bus.busy, 1'b0);
      check({tag, "_sum"}, bus.sum, s);
      check({tag, "_cout"}, bus.cout, c);
      check({tag, "_ovf"}, bus.overflow, o);
   endtask

   task automatic op(input logic [15:0] x, input logic [15:0] y, input logic cin, input logic sub,
                     input logic [15:0] s, input logic c, input logic o, input string tag);
      int cnt;
      launch(x, y, cin, sub, tag);
      wait_done(20, cnt);
      check({tag, "_lat"}, cnt, 4);
      check_result(tag, s, c, o);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_done"}, bus.done, 1'b0);
      check({tag, "_sum"}, bus.sum, 16'h0000);
      check({tag, "_cout"}, bus.cout, 1'b0);
      check({tag, "_ovf"}, bus.overflow, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with random inputs and start asserted
      rst_n = 1'b0;
      bus.start = 1'b1; bus.sub = 1'($urandom); bus.cin = 1'($urandom);
      bus.x = 16'($urandom); bus.y = 16'($urandom);
      #23;
      check_reset_outputs("rst");
      @(negedge clk);
      bus.start = 1'b0;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_busy", bus.busy, 1'b0);
         check("idle_done", bus.done, 1'b0);
      end

      op(16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0, "add");
      op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
      op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "addovf");
      op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub");
      op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "subovf");

      // start pulsed mid-RUN must be ignored
      launch(16'h1111, 16'h2222, 1'b0, 1'b0, "ign");
      @(posedge clk); #1;
      check("ign_sum_hold1", bus.sum, 16'h7FFF);
      bus.x = 16'hAAAA; bus.y = 16'h5555; bus.cin = 1'b1; bus.sub = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("ign_busy_mid", bus.busy, 1'b1);
      check("ign_sum_hold2", bus.sum, 16'h7FFF);
      wait_done(20, n);
      check("ign_lat", n, 2);
      check_result("ign", 16'h3333, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         check("ign_no_relaunch", bus.busy, 1'b0);
      end

      // Back-to-back: start held in the DONE cycle
      launch(16'h0001, 16'h0002, 1'b0, 1'b0, "b2b_a");
      wait_done(20, n);
      check("b2b_a_lat", n, 4);
      bus.x = 16'h00FF; bus.y = 16'h0F01; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      check_result("b2b_a", 16'h0003, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("b2b_b_busy", bus.busy, 1'b1);
      check("b2b_b_sum_hold", bus.sum, 16'h0003);
      wait_done(20, n2);
      check("b2b_gap", n2 + 1, 5);
      check_result("b2b_b", 16'h1000, 1'b0, 1'b0);

      // Reset at RUN idx=2
      launch(16'h4321, 16'h1111, 1'b0, 1'b0, "mid");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) begin
         @(posedge clk); #1;
         check("midrst_no_done", bus.done, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      op(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, "post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
